// File: rtl/clk_speed_timer.sv
// Two-digit BCD countdown timer stepped by rising edges of a selectable slow divider output.
// Optional build macro: CLK_TIMER_AUTO_RELOAD_EN (on expiry, reload the last start value and keep running).
module clk_speed_timer #(
  parameter logic [1:0] SEL_RESET   = 2'd2,
  parameter logic [7:0] DEFAULT_VAL = 8'h30
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       c025hz,
  input  logic       c05hz,
  input  logic       c1hz,
  input  logic       c2hz,
  input  logic [1:0] sel,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] load_val,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q;
  logic       src;
  logic       smp_q;
  logic       prev_q;
  logic [1:0] sel_q;
  logic       tick;
  logic [7:0] load;
  logic [7:0] dec;

  // SEL_RESET only records the divider's power-up choice; sel is always honoured.
  logic sel_reset_unused;
  assign sel_reset_unused = ^SEL_RESET;

  function automatic logic [7:0] sanitise(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = v[7:4];
    u = v[3:0];
    if (t > 4'd9 && u > 4'd9) return DEFAULT_VAL;
    if (t > 4'd9) t = 4'd9;
    if (u > 4'd9) u = 4'd9;
    return {t, u};
  endfunction

  always_comb begin
    src = c025hz;
    case (sel)
      2'd0:    src = c025hz;
      2'd1:    src = c05hz;
      2'd2:    src = c1hz;
      default: src = c2hz;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (!reset) begin
      smp_q  <= 1'b0;
      prev_q <= 1'b0;
      sel_q  <= sel;
    end else begin
      smp_q  <= src;
      prev_q <= smp_q;
      sel_q  <= sel;
    end
  end

  // A sel change masks the edge detector for the cycle in which sel and sel_q disagree.
  assign tick = smp_q & ~prev_q & (sel == sel_q);
  assign load = sanitise(load_val);

  always_comb begin
    if (units != 4'd0)     dec = {tens, units - 4'd1};
    else if (tens != 4'd0) dec = {tens - 4'd1, 4'd9};
    else                   dec = 8'h00;
  end

`ifdef CLK_TIMER_AUTO_RELOAD_EN
  logic [7:0] last_q;

  always_ff @(posedge clock_50) begin
    if (!reset)     last_q <= 8'h00;
    else if (start) last_q <= load;
  end
`endif

  always_ff @(posedge clock_50) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tens    <= 4'd0;
      units   <= 4'd0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            {tens, units} <= load;
            if (load == 8'h00) begin
              state_q <= S_DONE;
              done    <= 1'b1;
              running <= 1'b0;
              expired <= 1'b1;
            end else begin
              state_q <= S_RUN;
              running <= 1'b1;
              expired <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (start) begin
            {tens, units} <= load;
          end else if (pause) begin
            state_q <= S_PAUSE;
            running <= 1'b0;
          end else if (tick && {tens, units} == 8'h01) begin
            done <= 1'b1;
`ifdef CLK_TIMER_AUTO_RELOAD_EN
            {tens, units} <= last_q;
`else
            {tens, units} <= 8'h00;
            state_q       <= S_DONE;
            running       <= 1'b0;
            expired       <= 1'b1;
`endif
          end else if (tick) begin
            {tens, units} <= dec;
          end
        end
        S_PAUSE: begin
          // Ticks arriving here are dropped; the edge detector keeps tracking.
          if (start) begin
            {tens, units} <= load;
            state_q       <= S_RUN;
            running       <= 1'b1;
          end else if (!pause) begin
            state_q <= S_RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          running <= 1'b0;
          expired <= 1'b0;
        end
      endcase
    end
  end

endmodule
